i2c_cfg_sequencer: RTL and testbench
====================================

Name: i2c_cfg_sequencer

Overview:
- Walks a fixed table of register writes (e.g. audio codec / video decoder init) and drives the 24-bit I2C write engine once per entry.
- Generates the engine's step strobe (en) and bit-phase clock (i2c_iclk).
- Handles the GO/END handshake, retries NACKed writes, and reports done/error to top-level control logic.
- Sits between the board reset/start logic and the I2C engine instance.

Parameters:
- NUM_REGS, 10, number of table entries; indices 0..NUM_REGS-1.
- SLAVE_ADDR, 8'h34, 8-bit write address: 7-bit device address plus R/W=0.
- STEP_DIV, 250, CLOCK cycles per engine step. Must be even and >=4.
- MAX_RETRY, 3, extra attempts per entry after a NACK or timeout.
- GAP_STEPS, 4, en strobes with go low between transfers.
- TIMEOUT_STEPS, 80, en strobes allowed per transfer before it is declared failed.

Ports:
- CLOCK  in  1  system clock.
- nRESET  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; (re)runs the table from index 0. Ignored while busy.
- en  out  1  one-CLOCK-cycle strobe every STEP_DIV cycles.
- i2c_iclk  out  1  bit-phase clock to the engine.
- i2c_data  out  24  {SLAVE_ADDR, sub_addr[7:0], data[7:0]}.
- go  out  1  engine transfer request.
- i2c_end  in  1  engine END.
- i2c_ack  in  1  engine ACK; 1 = NACK seen.
- busy  out  1  sequence in progress.
- done  out  1  sticky; all entries written.
- error  out  1  sticky; an entry exhausted its retries.
- reg_index  out  $clog2(NUM_REGS)  current or failing entry.

Behaviour:
- Async reset: en=0, i2c_iclk=0, go=0, i2c_data=0, busy=0, done=0, error=0, reg_index=0, state IDLE, all counters 0.
- Divider: div_cnt counts 0..STEP_DIV-1 and wraps.
  - en=1 when div_cnt==STEP_DIV-1.
  - i2c_iclk=1 while div_cnt < STEP_DIV/2, else 0.
  - The divider free-runs from reset and is never gated by the FSM.
- All FSM transitions that depend on engine outputs are evaluated only on cycles where en=1.
- FSM states:
  - IDLE: busy=0. On start: reg_index=0, retry=0, done=0, error=0, go to LOAD.
  - LOAD: latch i2c_data from table[reg_index]; go to GAP.
  - GAP: go=0. Count GAP_STEPS en strobes, then go=1 and move to WAIT_LOW.
  - WAIT_LOW: wait for i2c_end==0, i.e. engine started.
  - WAIT_HIGH: wait for i2c_end==1, then go to CHECK.
  - CHECK (one en step):
    - If i2c_ack==0: reg_index+1 and retry=0. If that was the last entry, set done and go to IDLE; otherwise go to LOAD.
    - If i2c_ack==1 and retry<MAX_RETRY: retry+1, go to LOAD with the same index.
    - Otherwise: set error, freeze reg_index at the failing entry, go to IDLE.
  - go drops to 0 on leaving CHECK.
- Timeout: xfer_cnt counts en strobes in WAIT_LOW and WAIT_HIGH and clears on entering WAIT_LOW. At TIMEOUT_STEPS, jump to CHECK and treat the transfer as a NACK.
- i2c_data is stable for the whole time go=1.
- busy=1 in every state except IDLE.
- Start while busy: ignored. Start in IDLE after done or error: clears both flags and reruns from index 0.
- Reset mid-transfer: go drops immediately (async), which aborts the engine. No partial state is retained.
- Index width: reg_index never exceeds NUM_REGS-1. The done check compares against NUM_REGS-1 before incrementing, so there is no wrap.

Optional Feature:
- Macro: I2C_CFG_AUTOSTART_EN.
- Defined:
  - After nRESET deasserts, a 20-bit power-up counter runs for 2^20 CLOCK cycles, then an internal start pulse fires once.
  - The start port still works afterwards.
- Undefined:
  - The counter is absent; the sequence runs only on the start port.

Decomposition:
- Package i2c_cfg_pkg holds:
  - the FSM state enum;
  - the 16-bit entry type {sub_addr, data};
  - the constant table function cfg_entry(index), returning 16'h0000 for out-of-range indices;
  - default constants (SLAVE_ADDR, GAP_STEPS).
- One sub-module, i2c_step_gen: the en/i2c_iclk divider, parameterised by STEP_DIV.
- The FSM, retry and timeout counters stay in i2c_cfg_sequencer.

Test Plan:
- Bench setup: behavioural engine model plus an I2C slave model, with STEP_DIV=8, NUM_REGS=3, table {0x1E00, 0x0C00, 0x1201}.
- Normal run: start pulse → three transfers with i2c_data=0x341E00, 0x340C00, 0x341201 in that order; done=1, error=0, busy=0; en period exactly 8 cycles.
- Single retry: slave NACKs the first attempt of entry 1 → entry 1 sent twice, done=1, error=0.
- Retry exhaustion: slave NACKs entry 2 every time → exactly 4 attempts (1+MAX_RETRY), then error=1, reg_index=2, done=0.
- Timeout: engine model holds END high forever → timeout after 80 en strobes, retries per the NACK rules, error=1.
- Reset and restart: nRESET pulsed during entry 1 → go=0 and busy=0 in the same cycle; a later start reruns from 0x341E00. A start pulsed while busy has no effect.
- Autostart (I2C_CFG_AUTOSTART_EN defined): with no start pulse, the first go rises 2^20 + 4·8 cycles after reset release, within ±8 cycles.

Source files
------------

// File: rtl/i2c_cfg_pkg.sv
// Shared types, defaults and the register-write table for the I2C configuration sequencer.
package i2c_cfg_pkg;

   localparam logic [7:0] SLAVE_ADDR_DEF = 8'h34;
   localparam int         GAP_STEPS_DEF  = 4;

   typedef enum logic [2:0] {
      IDLE,
      LOAD,
      GAP,
      WAIT_LOW,
      WAIT_HIGH,
      CHECK
   } state_t;

   typedef struct packed {
      logic [7:0] sub_addr;
      logic [7:0] data;
   } entry_t;

   // Codec init order: reset, power-up, activate first; the rest is audio path setup.
   function automatic entry_t cfg_entry(input int index);
      case (index)
         0:       cfg_entry = entry_t'(16'h1E00);
         1:       cfg_entry = entry_t'(16'h0C00);
         2:       cfg_entry = entry_t'(16'h1201);
         3:       cfg_entry = entry_t'(16'h001A);
         4:       cfg_entry = entry_t'(16'h021A);
         5:       cfg_entry = entry_t'(16'h047B);
         6:       cfg_entry = entry_t'(16'h067B);
         7:       cfg_entry = entry_t'(16'h08F8);
         8:       cfg_entry = entry_t'(16'h0A06);
         9:       cfg_entry = entry_t'(16'h0E01);
         default: cfg_entry = entry_t'(16'h0000);
      endcase
   endfunction

endpackage

// File: rtl/i2c_cfg_sequencer_step_gen.sv
// Free-running step divider: one-cycle en strobe and half-duty bit-phase clock per STEP_DIV cycles.
module i2c_step_gen #(
   parameter int STEP_DIV = 250
) (
   input  logic CLOCK,
   input  logic nRESET,
   output logic en,
   output logic i2c_iclk
);

   localparam int              CNT_W = $clog2(STEP_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(STEP_DIV - 1);
   localparam logic [CNT_W-1:0] HALF = CNT_W'(STEP_DIV / 2);

   logic [CNT_W-1:0] div_cnt;
   logic [CNT_W-1:0] div_nxt;

   assign div_nxt = (div_cnt == LAST) ? '0 : div_cnt + 1'b1;

   // Outputs are registered from the next count so both read 0 during reset.
   always_ff @(posedge CLOCK or negedge nRESET) begin
      if (!nRESET) begin
         div_cnt  <= '0;
         en       <= 1'b0;
         i2c_iclk <= 1'b0;
      end else begin
         div_cnt  <= div_nxt;
         en       <= (div_nxt == LAST);
         i2c_iclk <= (div_nxt < HALF);
      end
   end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Table-driven I2C register-write sequencer with retry and timeout.
// Optional build macro I2C_CFG_AUTOSTART_EN adds a one-shot start 2^20 cycles after reset.
module i2c_cfg_sequencer
   import i2c_cfg_pkg::*;
#(
   parameter int         NUM_REGS      = 10,
   parameter logic [7:0] SLAVE_ADDR    = SLAVE_ADDR_DEF,
   parameter int         STEP_DIV      = 250,
   parameter int         MAX_RETRY     = 3,
   parameter int         GAP_STEPS     = GAP_STEPS_DEF,
   parameter int         TIMEOUT_STEPS = 80
) (
   input  logic                        CLOCK,
   input  logic                        nRESET,
   input  logic                        start,
   output logic                        en,
   output logic                        i2c_iclk,
   output logic [23:0]                 i2c_data,
   output logic                        go,
   input  logic                        i2c_end,
   input  logic                        i2c_ack,
   output logic                        busy,
   output logic                        done,
   output logic                        error,
   output logic [$clog2(NUM_REGS)-1:0] reg_index
);

   localparam int IDX_W = $clog2(NUM_REGS);
   localparam int RTY_W = $clog2(MAX_RETRY + 2);
   localparam int GAP_W = $clog2(GAP_STEPS + 1);
   localparam int TO_W  = $clog2(TIMEOUT_STEPS + 1);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
   localparam logic [RTY_W-1:0] MAX_RTY  = RTY_W'(MAX_RETRY);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_STEPS - 1);
   localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_STEPS - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] idx_nxt;
   logic [RTY_W-1:0] retry, retry_nxt;
   logic [GAP_W-1:0] gap_cnt, gap_nxt;
   logic [TO_W-1:0]  xfer_cnt, xfer_nxt;
   logic             timed_out, timed_out_nxt;
   logic             go_nxt, done_nxt, error_nxt;
   logic [23:0]      data_nxt;
   logic             start_int;

   i2c_step_gen #(.STEP_DIV(STEP_DIV)) u_step_gen (
      .CLOCK    (CLOCK),
      .nRESET   (nRESET),
      .en       (en),
      .i2c_iclk (i2c_iclk)
   );

`ifdef I2C_CFG_AUTOSTART_EN
   logic [19:0] pwr_cnt;
   logic        pwr_done;
   logic        auto_start;

   always_ff @(posedge CLOCK or negedge nRESET) begin
      if (!nRESET) begin
         pwr_cnt    <= '0;
         pwr_done   <= 1'b0;
         auto_start <= 1'b0;
      end else begin
         auto_start <= 1'b0;
         if (!pwr_done) begin
            pwr_cnt <= pwr_cnt + 1'b1;
            if (pwr_cnt == 20'hFFFFF) begin
               pwr_done   <= 1'b1;
               auto_start <= 1'b1;
            end
         end
      end
   end

   assign start_int = start | auto_start;
`else
   assign start_int = start;
`endif

   assign busy = (state != IDLE);

   always_ff @(posedge CLOCK or negedge nRESET) begin
      if (!nRESET) begin
         state     <= IDLE;
         reg_index <= '0;
         retry     <= '0;
         gap_cnt   <= '0;
         xfer_cnt  <= '0;
         timed_out <= 1'b0;
         go        <= 1'b0;
         i2c_data  <= '0;
         done      <= 1'b0;
         error     <= 1'b0;
      end else begin
         state     <= state_nxt;
         reg_index <= idx_nxt;
         retry     <= retry_nxt;
         gap_cnt   <= gap_nxt;
         xfer_cnt  <= xfer_nxt;
         timed_out <= timed_out_nxt;
         go        <= go_nxt;
         i2c_data  <= data_nxt;
         done      <= done_nxt;
         error     <= error_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      idx_nxt       = reg_index;
      retry_nxt     = retry;
      gap_nxt       = gap_cnt;
      xfer_nxt      = xfer_cnt;
      timed_out_nxt = timed_out;
      go_nxt        = go;
      data_nxt      = i2c_data;
      done_nxt      = done;
      error_nxt     = error;
      case (state)
         IDLE: begin
            if (start_int) begin
               idx_nxt   = '0;
               retry_nxt = '0;
               done_nxt  = 1'b0;
               error_nxt = 1'b0;
               state_nxt = LOAD;
            end
         end
         LOAD: begin
            data_nxt  = {SLAVE_ADDR, cfg_entry(int'(reg_index))};
            gap_nxt   = '0;
            state_nxt = GAP;
         end
         GAP: begin
            go_nxt = 1'b0;
            if (en) begin
               if (gap_cnt == GAP_LAST) begin
                  go_nxt        = 1'b1;
                  xfer_nxt      = '0;
                  timed_out_nxt = 1'b0;
                  state_nxt     = WAIT_LOW;
               end else begin
                  gap_nxt = gap_cnt + 1'b1;
               end
            end
         end
         WAIT_LOW, WAIT_HIGH: begin
            if (en) begin
               xfer_nxt = xfer_cnt + 1'b1;
               if (state == WAIT_LOW && !i2c_end) begin
                  state_nxt = WAIT_HIGH;
               end else if (state == WAIT_HIGH && i2c_end) begin
                  state_nxt = CHECK;
               end else if (xfer_cnt >= TO_LAST) begin
                  timed_out_nxt = 1'b1;
                  state_nxt     = CHECK;
               end
            end
         end
         CHECK: begin
            if (en) begin
               go_nxt = 1'b0;
               if (!i2c_ack && !timed_out) begin
                  retry_nxt = '0;
                  if (reg_index == LAST_IDX) begin
                     done_nxt  = 1'b1;
                     state_nxt = IDLE;
                  end else begin
                     idx_nxt   = reg_index + 1'b1;
                     state_nxt = LOAD;
                  end
               end else if (retry < MAX_RTY) begin
                  retry_nxt = retry + 1'b1;
                  state_nxt = LOAD;
               end else begin
                  error_nxt = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Randomized bench: behavioural engine + NACK-scripted slave against a transfer-list reference model.
module tb_i2c_cfg_sequencer;

   localparam int NREG = 3;
   localparam int SDIV = 8;
   localparam int MAXR = 3;

   logic        CLOCK = 1'b0;
   logic        nRESET = 1'b0;
   logic        start = 1'b0;
   logic        en, i2c_iclk, go, busy, done, error;
   logic        i2c_end, i2c_ack;
   logic [23:0] i2c_data;
   logic [1:0]  reg_index;

   i2c_cfg_sequencer #(.NUM_REGS(NREG), .STEP_DIV(SDIV)) dut (
      .CLOCK     (CLOCK),
      .nRESET    (nRESET),
      .start     (start),
      .en        (en),
      .i2c_iclk  (i2c_iclk),
      .i2c_data  (i2c_data),
      .go        (go),
      .i2c_end   (i2c_end),
      .i2c_ack   (i2c_ack),
      .busy      (busy),
      .done      (done),
      .error     (error),
      .reg_index (reg_index)
   );

   always #5 CLOCK = ~CLOCK;

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [15:0] tbl [NREG] = '{16'h1E00, 16'h0C00, 16'h1201};
   logic [23:0] sent_q [$];
   logic [23:0] exp_q  [$];
   int          nack_left [NREG];
   bit          hold_end = 1'b0;
   int          stable_viol = 0;

   // Engine: accepts go, drops END, runs a few steps, raises END with the slave's answer.
   initial begin
      int          phase;
      int          run;
      logic [23:0] cap;
      phase = 0; run = 0; cap = '0;
      i2c_end = 1'b1;
      i2c_ack = 1'b0;
      forever begin
         @(negedge CLOCK);
         if (!nRESET) begin
            phase = 0; i2c_end = 1'b1; i2c_ack = 1'b0;
         end else begin
            case (phase)
               0: if (go) begin
                  cap = i2c_data;
                  sent_q.push_back(cap);
                  if (hold_end) phase = 2;
                  else begin
                     i2c_end = 1'b0;
                     run = 2 + int'($urandom_range(0, 6));
                     phase = 1;
                  end
               end
               1: begin
                  if (i2c_data !== cap) stable_viol++;
                  if (en) begin
                     run--;
                     if (run == 0) begin
                        i2c_end = 1'b1;
                        i2c_ack = 1'b0;
                        for (int j = 0; j < NREG; j++)
                           if ({8'h34, tbl[j]} == cap && nack_left[j] > 0) begin
                              nack_left[j]--;
                              i2c_ack = 1'b1;
                           end
                        phase = 2;
                     end
                  end
               end
               default: begin
                  if (!go) phase = 0;
                  else if (i2c_data !== cap) stable_viol++;
               end
            endcase
         end
      end
   end

   // Reference: each entry is tried until ACKed, at most 1+MAXR times; a timeout is a NACK.
   task automatic build_expect(input int n0, input int n1, input int n2, input bit to,
                               output bit e_done, output bit e_err, output int e_idx);
      int plan [NREG];
      int tries;
      plan = '{n0, n1, n2};
      exp_q.delete();
      e_err = 1'b0;
      e_idx = NREG - 1;
      for (int i = 0; i < NREG; i++) begin
         tries = to ? 1000 : plan[i];
         for (int k = 0; k <= ((tries > MAXR) ? MAXR : tries); k++)
            exp_q.push_back({8'h34, tbl[i]});
         if (tries > MAXR) begin
            e_err = 1'b1;
            e_idx = i;
            break;
         end
      end
      e_done = !e_err;
   endtask

   task automatic pulse_start();
      @(negedge CLOCK); start = 1'b1;
      @(negedge CLOCK); start = 1'b0;
   endtask

   task automatic run_case(input string name, input int n0, input int n1, input int n2, input bit to);
      bit e_done, e_err;
      int e_idx, cyc, nsent;
      nack_left = '{n0, n1, n2};
      hold_end = to;
      sent_q.delete();
      stable_viol = 0;
      build_expect(n0, n1, n2, to, e_done, e_err, e_idx);
      pulse_start();
      chk({name, ":busy_set"}, busy, 1'b1);
      cyc = 0;
      while (busy && cyc < 8000) begin
         @(negedge CLOCK);
         cyc++;
         if (cyc == 200 && busy) begin
            start = 1'b1;
            @(negedge CLOCK);
            start = 1'b0;
         end
      end
      chk({name, ":busy_clr"}, busy, 1'b0);
      nsent = sent_q.size();
      chk({name, ":count"}, nsent, exp_q.size());
      for (int i = 0; i < nsent && i < exp_q.size(); i++)
         chk($sformatf("%s:xfer%0d", name, i), sent_q[i], exp_q[i]);
      chk({name, ":done"}, done, e_done);
      chk({name, ":error"}, error, e_err);
      chk({name, ":reg_index"}, reg_index, e_idx);
      chk({name, ":go_low"}, go, 1'b0);
      chk({name, ":data_stable"}, stable_viol, 0);
   endtask

   initial begin
      int cnt, hi, wt;
      #1;
      chk("rst:go", go, 1'b0);
      chk("rst:busy", busy, 1'b0);
      chk("rst:done", done, 1'b0);
      chk("rst:error", error, 1'b0);
      chk("rst:en", en, 1'b0);
      chk("rst:iclk", i2c_iclk, 1'b0);
      chk("rst:data", i2c_data, 24'h0);
      chk("rst:idx", reg_index, 2'd0);
      repeat (3) @(negedge CLOCK);
      nRESET = 1'b1;

      wt = 0;
      while (!en && wt < 40) begin @(negedge CLOCK); wt++; end
      chk("en_seen", en, 1'b1);
      for (int p = 0; p < 3; p++) begin
         cnt = 0; hi = 0;
         do begin
            @(negedge CLOCK);
            cnt++;
            if (i2c_iclk) hi++;
         end while (!en && cnt < 20);
         chk("en_period", cnt, SDIV);
         chk("iclk_high", hi, SDIV / 2);
      end

      run_case("normal", 0, 0, 0, 1'b0);
      run_case("retry1", 0, 1, 0, 1'b0);
      run_case("exhaust2", 0, 0, 9, 1'b0);
      run_case("timeout", 0, 0, 0, 1'b1);

      nack_left = '{0, 0, 0};
      hold_end = 1'b0;
      sent_q.delete();
      pulse_start();
      wt = 0;
      while (!(sent_q.size() == 2 && go) && wt < 3000) begin @(negedge CLOCK); wt++; end
      chk("mid:entry1_go", go, 1'b1);
      @(posedge CLOCK);
      #2 nRESET = 1'b0;
      #1;
      chk("mid:go_drop", go, 1'b0);
      chk("mid:busy_drop", busy, 1'b0);
      chk("mid:data_clr", i2c_data, 24'h0);
      repeat (3) @(negedge CLOCK);
      nRESET = 1'b1;
      run_case("restart", 0, 0, 0, 1'b0);

      for (int r = 0; r < 6; r++)
         run_case($sformatf("rand%0d", r), int'($urandom_range(0, 4)),
                  int'($urandom_range(0, 4)), int'($urandom_range(0, 4)), 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
